dcache_direct_wb: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the core's MEM stage
//  (the data-memory port feeding the WB_Data_WB path) and a line-wide main-memory model.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/dcache_mem_model.sv | 75 +++++++
 rtl/dcache_direct_wb.sv | 135 +++++++++++++
 tb/tb_dcache_direct_wb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: FSM state encoding, field widths and byte-merge helper.
// Used by both the D-cache and the I-cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } cache_state_t;

    localparam int WORD_ADDR    = 2;
    localparam int LINE_SIZE    = 1 << 3;
    localparam int SET_SIZE     = 1 << 3;
    localparam int MEM_ADDR_LEN = 30 - 3;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_mem_model.sv
// Simulation main-memory model: line-wide array with a fixed grant latency.
// Lines never written return a deterministic pattern {line index, 16'hB000 | word}.
module dcache_mem_model
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 12,
    parameter int LATENCY       = 50
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rd_req,
    input  logic                             wr_req,
    input  logic [29-LINE_ADDR_LEN:0]        addr,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]   wr_line,
    output logic [(32<<LINE_ADDR_LEN)-1:0]   rd_line,
    output logic                             gnt
);

    localparam int IDX_W  = TAG_ADDR_LEN + SET_ADDR_LEN;
    localparam int NLINES = 1 << IDX_W;
    localparam int WORDS  = 1 << LINE_ADDR_LEN;
    localparam int LBITS  = 32 << LINE_ADDR_LEN;

    logic [LBITS-1:0]  mem [NLINES];
    logic [NLINES-1:0] written;
    logic [15:0]       cnt;
    logic [IDX_W-1:0]  idx;
    logic              unused_addr;

    assign idx         = addr[IDX_W-1:0];
    assign unused_addr = ^addr[29-LINE_ADDR_LEN:IDX_W];

    function automatic logic [LBITS-1:0] pattern_line(input logic [IDX_W-1:0] line_idx);
        logic [LBITS-1:0] l;
        for (int w = 0; w < WORDS; w++) begin
            l[w*32 +: 32] = {16'(line_idx), 16'hB000 | 16'(w)};
        end
        return l;
    endfunction

    // Grant pulses for one cycle after LATENCY cycles of a held request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            gnt     <= 1'b0;
            rd_line <= '0;
            written <= '0;
        end else if (gnt) begin
            gnt <= 1'b0;
            cnt <= '0;
        end else if (rd_req || wr_req) begin
            if (cnt == 16'(LATENCY - 1)) begin
                gnt <= 1'b1;
                if (wr_req) begin
                    written[idx] <= 1'b1;
                end else begin
                    rd_line <= written[idx] ? mem[idx] : pattern_line(idx);
                end
            end else begin
                cnt <= cnt + 16'd1;
            end
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !gnt && wr_req && cnt == 16'(LATENCY - 1)) begin
            mem[idx] <= wr_line;
        end
    end

endmodule

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a swap-out/swap-in miss FSM.
// Hits complete in the request cycle; misses hold miss_stall until the refilled line hits.
module dcache_direct_wb
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rd_req,
    input  logic                             wr_req,
    input  logic [31:0]                      addr,
    input  logic [3:0]                       wr_be,
    input  logic [31:0]                      wr_data,
    output logic [31:0]                      rd_data,
    output logic                             miss_stall,
    output logic                             mem_rd_req,
    output logic                             mem_wr_req,
    output logic [29-LINE_ADDR_LEN:0]        mem_addr,
    output logic [(32<<LINE_ADDR_LEN)-1:0]   mem_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]   mem_rd_line,
    input  logic                             mem_gnt
);

    localparam int SETS  = 1 << SET_ADDR_LEN;
    localparam int LBITS = 32 << LINE_ADDR_LEN;
    localparam int MAW   = 30 - LINE_ADDR_LEN;
    localparam int HI    = WORD_ADDR + LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN;

    logic [LBITS-1:0]        data_array [SETS];
    logic [TAG_ADDR_LEN-1:0] tag_array  [SETS];
    logic [SETS-1:0]         valid;
    logic [SETS-1:0]         dirty;

    cache_state_t            state;
    logic [TAG_ADDR_LEN-1:0] miss_tag;
    logic [SET_ADDR_LEN-1:0] miss_set;
    logic [LBITS-1:0]        fill_line;

    logic                     req;
    logic                     hit;
    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_ADDR_LEN-1:0]  tag_in;
    logic [31:0]              hit_word;
    logic                     unused_addr;

    assign req         = rd_req | wr_req;
    assign word_idx    = addr[WORD_ADDR +: LINE_ADDR_LEN];
    assign set_idx     = addr[WORD_ADDR + LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign tag_in      = addr[WORD_ADDR + LINE_ADDR_LEN + SET_ADDR_LEN +: TAG_ADDR_LEN];
    assign unused_addr = ^{addr[WORD_ADDR-1:0], addr[31:HI]};

    assign hit      = req && (state == IDLE) && valid[set_idx] && (tag_array[set_idx] == tag_in);
    assign hit_word = data_array[set_idx][32*word_idx +: 32];

    // A simultaneous rd_req/wr_req is a store, so only pure loads return data.
    assign miss_stall = !rst && req && !hit;
    assign rd_data    = (!rst && hit && rd_req && !wr_req) ? hit_word : 32'd0;

    // Miss FSM; memory request outputs are registered and stay stable until mem_gnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            dirty       <= '0;
            miss_tag    <= '0;
            miss_set    <= '0;
            fill_line   <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_line <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && wr_req) begin
                        dirty[set_idx] <= 1'b1;
                    end else if (req && !hit) begin
                        miss_tag <= tag_in;
                        miss_set <= set_idx;
                        if (valid[set_idx] && dirty[set_idx]) begin
                            state       <= SWAP_OUT;
                            mem_wr_req  <= 1'b1;
                            mem_addr    <= MAW'({tag_array[set_idx], set_idx});
                            mem_wr_line <= data_array[set_idx];
                        end else begin
                            state      <= SWAP_IN;
                            mem_rd_req <= 1'b1;
                            mem_addr   <= MAW'({tag_in, set_idx});
                        end
                    end
                end
                SWAP_OUT: begin
                    if (mem_gnt) begin
                        state       <= SWAP_IN;
                        mem_wr_req  <= 1'b0;
                        mem_wr_line <= '0;
                        mem_rd_req  <= 1'b1;
                        mem_addr    <= MAW'({miss_tag, miss_set});
                    end
                end
                SWAP_IN: begin
                    if (mem_gnt) begin
                        state      <= SWAP_IN_OK;
                        fill_line  <= mem_rd_line;
                        mem_rd_req <= 1'b0;
                        mem_addr   <= '0;
                    end
                end
                SWAP_IN_OK: begin
                    state           <= IDLE;
                    valid[miss_set] <= 1'b1;
                    dirty[miss_set] <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line and tag storage carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == IDLE && hit && wr_req) begin
                data_array[set_idx][32*word_idx +: 32] <= merge_bytes(hit_word, wr_data, wr_be);
            end else if (state == SWAP_IN_OK) begin
                data_array[miss_set] <= fill_line;
                tag_array[miss_set]  <= miss_tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed and scoreboard checks of dcache_direct_wb against a short-latency memory model.
module tb_dcache_direct_wb;

    localparam int LAT    = 4;
    localparam int BUDGET = 8 * LAT + 20;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mem_rst = 1'b0;
    logic         rd_req = 1'b0;
    logic         wr_req = 1'b0;
    logic [31:0]  addr = '0;
    logic [3:0]   wr_be = '0;
    logic [31:0]  wr_data = '0;
    logic [31:0]  rd_data;
    logic         miss_stall;
    logic         mem_rd_req;
    logic         mem_wr_req;
    logic [26:0]  mem_addr;
    logic [255:0] mem_wr_line;
    logic [255:0] mem_rd_line;
    logic         mem_gnt;

    int n_compared = 0;
    int n_mismatch = 0;

    int           wb_count = 0;
    int           fill_count = 0;
    int           wr_cycles = 0;
    bit           both_seen = 0;
    logic [26:0]  last_wb_addr = '0;
    logic [255:0] last_wb_line = '0;
    logic [26:0]  last_fill_addr = '0;

    always #5 clk = ~clk;

    dcache_direct_wb dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_be(wr_be), .wr_data(wr_data), .rd_data(rd_data), .miss_stall(miss_stall),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(mem_gnt)
    );

    dcache_mem_model #(.LATENCY(LAT)) mem (
        .clk(clk), .rst(mem_rst), .rd_req(mem_rd_req), .wr_req(mem_wr_req),
        .addr(mem_addr), .wr_line(mem_wr_line), .rd_line(mem_rd_line), .gnt(mem_gnt)
    );

    // Memory transaction monitor
    always @(negedge clk) begin
        if (mem_rd_req && mem_wr_req) both_seen = 1;
        if (mem_wr_req) wr_cycles++;
        if (mem_gnt && mem_wr_req) begin
            wb_count++;
            last_wb_addr = mem_addr;
            last_wb_line = mem_wr_line;
        end
        if (mem_gnt && mem_rd_req) begin
            fill_count++;
            last_fill_addr = mem_addr;
        end
    end

    function automatic logic [31:0] pat(input int line, input int w);
        return {line[15:0], 16'hB000 | w[15:0]};
    endfunction

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] d,
                             output logic [31:0] data, output bit stalled);
        int cyc;
        @(posedge clk); #1;
        rd_req = rd; wr_req = wr; addr = a; wr_be = be; wr_data = d;
        cyc = 0;
        @(negedge clk);
        stalled = miss_stall;
        while (miss_stall !== 1'b0 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        n_compared++;
        if (miss_stall !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL access_timeout addr=%08h: stall=%b want 0 within %0d cycles", a, miss_stall, BUDGET);
        end
        data = rd_data;
        @(posedge clk); #1;
        rd_req = 0; wr_req = 0;
    endtask

    task automatic test_reset;
        rst = 1; mem_rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_compared += 4;
        if (miss_stall !== 1'b0) begin n_mismatch++; $display("[TB] FAIL reset_stall: got %b want 0", miss_stall); end
        if (mem_rd_req !== 1'b0) begin n_mismatch++; $display("[TB] FAIL reset_mem_rd: got %b want 0", mem_rd_req); end
        if (mem_wr_req !== 1'b0) begin n_mismatch++; $display("[TB] FAIL reset_mem_wr: got %b want 0", mem_wr_req); end
        if (rd_data !== 32'd0) begin n_mismatch++; $display("[TB] FAIL reset_rd_data: got %08h want 0", rd_data); end
        rst = 0; mem_rst = 0;
        @(negedge clk);
        n_compared++;
        if (miss_stall !== 1'b0) begin n_mismatch++; $display("[TB] FAIL idle_no_req_stall: got %b want 0", miss_stall); end
    endtask

    task automatic test_cold_read;
        logic [31:0] d; bit st; int f0, w0;
        f0 = fill_count; w0 = wb_count;
        do_access(1, 0, 32'h40, 4'h0, 32'h0, d, st);
        n_compared += 5;
        if (st !== 1'b1) begin n_mismatch++; $display("[TB] FAIL cold_stall: got %b want 1", st); end
        if (fill_count - f0 != 1) begin n_mismatch++; $display("[TB] FAIL cold_fills: got %0d want 1", fill_count - f0); end
        if (wb_count != w0) begin n_mismatch++; $display("[TB] FAIL cold_no_wb: got %0d want 0", wb_count - w0); end
        if (last_fill_addr !== 27'h2) begin n_mismatch++; $display("[TB] FAIL cold_mem_addr: got %0h want 2", last_fill_addr); end
        if (d !== 32'h0002B000) begin n_mismatch++; $display("[TB] FAIL cold_data: got %08h want 0002b000", d); end
    endtask

    task automatic test_write_hit;
        logic [31:0] d; bit st;
        do_access(0, 1, 32'h44, 4'b1111, 32'hDEADBEEF, d, st);
        n_compared += 2;
        if (st !== 1'b0) begin n_mismatch++; $display("[TB] FAIL wr_hit_stall: got %b want 0", st); end
        if (d !== 32'd0) begin n_mismatch++; $display("[TB] FAIL wr_hit_rd_data: got %08h want 0", d); end
        do_access(1, 0, 32'h44, 4'h0, 32'h0, d, st);
        n_compared += 2;
        if (st !== 1'b0) begin n_mismatch++; $display("[TB] FAIL rd_hit_stall: got %b want 0", st); end
        if (d !== 32'hDEADBEEF) begin n_mismatch++; $display("[TB] FAIL rd_hit_full: got %08h want deadbeef", d); end
        do_access(0, 1, 32'h44, 4'b0010, 32'h00005500, d, st);
        do_access(1, 0, 32'h44, 4'h0, 32'h0, d, st);
        n_compared++;
        if (d !== 32'hDEAD55EF) begin n_mismatch++; $display("[TB] FAIL rd_hit_merge: got %08h want dead55ef", d); end
        do_access(1, 0, 32'h40, 4'h0, 32'h0, d, st);
        n_compared++;
        if (d !== 32'h0002B000) begin n_mismatch++; $display("[TB] FAIL rd_hit_neighbor: got %08h want 0002b000", d); end
    endtask

    task automatic test_dirty_evict;
        logic [31:0] d; bit st; int w0;
        do_access(0, 1, 32'h04, 4'b1111, 32'h12345678, d, st);
        w0 = wb_count;
        do_access(1, 0, 32'h400, 4'h0, 32'h0, d, st);
        n_compared += 6;
        if (wb_count - w0 != 1) begin n_mismatch++; $display("[TB] FAIL evict0_wb_count: got %0d want 1", wb_count - w0); end
        if (last_wb_addr !== 27'h0) begin n_mismatch++; $display("[TB] FAIL evict0_wb_addr: got %0h want 0", last_wb_addr); end
        if (last_wb_line[63:32] !== 32'h12345678) begin n_mismatch++; $display("[TB] FAIL evict0_wb_w1: got %08h want 12345678", last_wb_line[63:32]); end
        if (last_wb_line[31:0] !== 32'h0000B000) begin n_mismatch++; $display("[TB] FAIL evict0_wb_w0: got %08h want 0000b000", last_wb_line[31:0]); end
        if (last_fill_addr !== 27'h20) begin n_mismatch++; $display("[TB] FAIL evict0_fill_addr: got %0h want 20", last_fill_addr); end
        if (d !== 32'h0020B000) begin n_mismatch++; $display("[TB] FAIL evict0_data: got %08h want 0020b000", d); end
        do_access(1, 0, 32'h440, 4'h0, 32'h0, d, st);
        n_compared += 3;
        if (last_wb_addr !== 27'h2) begin n_mismatch++; $display("[TB] FAIL evict2_wb_addr: got %0h want 2", last_wb_addr); end
        if (last_wb_line[63:32] !== 32'hDEAD55EF) begin n_mismatch++; $display("[TB] FAIL evict2_wb_w1: got %08h want dead55ef", last_wb_line[63:32]); end
        if (d !== 32'h0022B000) begin n_mismatch++; $display("[TB] FAIL evict2_data: got %08h want 0022b000", d); end
        do_access(1, 0, 32'h44, 4'h0, 32'h0, d, st);
        n_compared += 2;
        if (st !== 1'b1) begin n_mismatch++; $display("[TB] FAIL refill_stall: got %b want 1", st); end
        if (d !== 32'hDEAD55EF) begin n_mismatch++; $display("[TB] FAIL refill_data: got %08h want dead55ef", d); end
    endtask

    task automatic test_clean_evict;
        logic [31:0] d; bit st; int w0, c0;
        w0 = wb_count; c0 = wr_cycles;
        do_access(1, 0, 32'h0, 4'h0, 32'h0, d, st);
        n_compared += 2;
        if (st !== 1'b1) begin n_mismatch++; $display("[TB] FAIL clean0_stall: got %b want 1", st); end
        if (d !== 32'h0000B000) begin n_mismatch++; $display("[TB] FAIL clean0_data: got %08h want 0000b000", d); end
        do_access(1, 0, 32'h400, 4'h0, 32'h0, d, st);
        n_compared += 3;
        if (d !== 32'h0020B000) begin n_mismatch++; $display("[TB] FAIL clean1_data: got %08h want 0020b000", d); end
        if (wb_count != w0) begin n_mismatch++; $display("[TB] FAIL clean_wb_count: got %0d want 0", wb_count - w0); end
        if (wr_cycles != c0) begin n_mismatch++; $display("[TB] FAIL clean_wr_req_cycles: got %0d want 0", wr_cycles - c0); end
    endtask

    task automatic test_reset_mid_miss;
        logic [31:0] d; bit st; int cyc, f0;
        f0 = fill_count;
        @(posedge clk); #1;
        rd_req = 1; addr = 32'h800;
        cyc = 0;
        @(negedge clk);
        while (mem_rd_req !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        n_compared++;
        if (mem_rd_req !== 1'b1) begin n_mismatch++; $display("[TB] FAIL rstmiss_swap_in: got %b want 1", mem_rd_req); end
        rst = 1;
        @(negedge clk);
        n_compared += 2;
        if (mem_rd_req !== 1'b0) begin n_mismatch++; $display("[TB] FAIL rstmiss_mem_rd_drop: got %b want 0", mem_rd_req); end
        if (miss_stall !== 1'b0) begin n_mismatch++; $display("[TB] FAIL rstmiss_stall: got %b want 0", miss_stall); end
        rst = 0; rd_req = 0;
        repeat (2 * LAT) @(negedge clk);
        n_compared++;
        if (fill_count != f0) begin n_mismatch++; $display("[TB] FAIL rstmiss_no_fill: got %0d want 0", fill_count - f0); end
        do_access(1, 0, 32'h400, 4'h0, 32'h0, d, st);
        n_compared += 2;
        if (st !== 1'b1) begin n_mismatch++; $display("[TB] FAIL rst_invalidates: got %b want 1", st); end
        if (d !== 32'h0020B000) begin n_mismatch++; $display("[TB] FAIL rst_reread_data: got %08h want 0020b000", d); end
        do_access(1, 0, 32'h800, 4'h0, 32'h0, d, st);
        n_compared += 2;
        if (st !== 1'b1) begin n_mismatch++; $display("[TB] FAIL rstmiss_again_stall: got %b want 1", st); end
        if (d !== 32'h0040B000) begin n_mismatch++; $display("[TB] FAIL rstmiss_again_data: got %08h want 0040b000", d); end
    endtask

    task automatic test_random_stream;
        logic [31:0] sb [int];
        bit          mvalid [8];
        int          mtag [8];
        logic [31:0] a, d, expv, nd;
        logic [3:0]  be;
        bit          st, is_wr, exp_hit;
        int          waddr, set, tag;
        for (int s = 0; s < 8; s++) begin mvalid[s] = 0; mtag[s] = 0; end
        for (int i = 0; i < 1500; i++) begin
            a     = 32'h1000 + ($urandom_range(0, 255) << 2);
            waddr = int'(a >> 2);
            set   = int'((a >> 5) & 32'h7);
            tag   = int'((a >> 8) & 32'hFFF);
            is_wr = ($urandom_range(0, 1) == 1);
            be    = 4'($urandom_range(1, 15));
            nd    = $urandom;
            expv  = sb.exists(waddr) ? sb[waddr] : pat(waddr >> 3, waddr & 7);
            exp_hit = mvalid[set] && (mtag[set] == tag);
            do_access(!is_wr, is_wr, a, be, nd, d, st);
            n_compared++;
            if (st !== !exp_hit) begin n_mismatch++; $display("[TB] FAIL rand_stall op%0d addr=%08h: got %b want %b", i, a, st, !exp_hit); end
            if (is_wr) begin
                for (int b = 0; b < 4; b++) if (be[b]) expv[b*8 +: 8] = nd[b*8 +: 8];
                sb[waddr] = expv;
            end else begin
                n_compared++;
                if (d !== expv) begin n_mismatch++; $display("[TB] FAIL rand_load op%0d addr=%08h: got %08h want %08h", i, a, d, expv); end
            end
            mvalid[set] = 1; mtag[set] = tag;
        end
        n_compared++;
        if (both_seen) begin n_mismatch++; $display("[TB] FAIL mem_req_exclusive: got both high want never"); end
    endtask

    initial begin
        test_reset;
        test_cold_read;
        test_write_hit;
        test_dirty_evict;
        test_clean_evict;
        test_reset_mid_miss;
        test_random_stream;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
